// File: rtl/alu_rr_sequencer_if.sv
// Request, response and ALU-side signals of the shared-ALU sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface alu_rr_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_opcode;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_opcode;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W:0]   rsp_data;
    logic              alu_en;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_out;

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        input  rsp_ready, alu_out,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
        output alu_en, alu_opcode, alu_a, alu_b
    );

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        output req1_valid, req1_opcode, req1_a, req1_b,
        output rsp_ready, alu_out,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
        input  alu_en, alu_opcode, alu_a, alu_b
    );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Round-robin share of one ALU between two requesters; one op in flight, IDLE->EXEC->RESP, 3 cycles/op.
// Response held until rsp_ready; requesters see ready only in IDLE, so a stalled response blocks both.
module alu_rr_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_rr_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W:0]   data_q, data_d;
    logic              gnt0, gnt1;

    // last_q remembers the previous winner; reset to 1 so req0 wins the first tie.
    always_comb begin
        gnt0 = bus.req0_valid & (~bus.req1_valid | last_q);
        gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (gnt0) begin
                    state_d = EXEC;
                    last_d  = 1'b0;
                    id_d    = 1'b0;
                    op_d    = bus.req0_opcode;
                    a_d     = bus.req0_a;
                    b_d     = bus.req0_b;
                end else if (gnt1) begin
                    state_d = EXEC;
                    last_d  = 1'b1;
                    id_d    = 1'b1;
                    op_d    = bus.req1_opcode;
                    a_d     = bus.req1_a;
                    b_d     = bus.req1_b;
                end
            end
            EXEC: begin
                data_d  = bus.alu_out;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
        end
    end

    // Ready is gated by rst_n so a requester holding valid sees no grant while in reset.
    assign bus.req0_ready = rst_n & (state_q == IDLE) & gnt0;
    assign bus.req1_ready = rst_n & (state_q == IDLE) & gnt1;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.alu_en     = (state_q == EXEC);
    assign bus.alu_opcode = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer with a behavioural ALU and an expected-response queue.
module tb_alu_rr_sequencer;
    localparam int DW = 32;
    localparam int OW = 3;

    typedef struct {
        logic        id;
        logic [DW:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_rr_sequencer_if #(.DATA_W(DW), .OP_W(OW)) bus ();

    alu_rr_sequencer #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL1 a, 7 EQ
    function automatic logic [DW:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        case (op)
            3'd0:    alu_f = {1'b0, a} + {1'b0, b};
            3'd1:    alu_f = {1'b0, a} - {1'b0, b};
            3'd2:    alu_f = {1'b0, a & b};
            3'd3:    alu_f = {1'b0, a | b};
            3'd4:    alu_f = {1'b0, a ^ b};
            3'd5:    alu_f = {1'b0, ~a};
            3'd6:    alu_f = {a, 1'b0};
            default: alu_f = {{DW{1'b0}}, (a == b)};
        endcase
    endfunction

    assign bus.alu_out = bus.alu_en ? alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b) : '0;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        tb_last;
    logic [DW:0] last_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
        chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
        chk({tag, "_alu_en"}, 64'(bus.alu_en), 64'd0);
        chk({tag, "_alu_opcode"}, 64'(bus.alu_opcode), 64'd0);
        chk({tag, "_alu_a"}, 64'(bus.alu_a), 64'd0);
        chk({tag, "_alu_b"}, 64'(bus.alu_b), 64'd0);
        chk({tag, "_ready"}, 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    endtask

    // Called at posedge+1; runs one full IDLE/EXEC/RESP transaction and returns at posedge+1.
    task automatic txn(input bit v0, input bit v1,
                       input logic [OW-1:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic [OW-1:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                       input int hold);
        bit              w;
        exp_t            e;
        logic [OW-1:0]   wop;
        logic [DW-1:0]   wa, wb;
        bus.req0_valid  = v0;
        bus.req0_opcode = op0;
        bus.req0_a      = a0;
        bus.req0_b      = b0;
        bus.req1_valid  = v1;
        bus.req1_opcode = op1;
        bus.req1_a      = a1;
        bus.req1_b      = b1;
        bus.rsp_ready   = (hold == 0);
        w       = (v0 && v1) ? !tb_last : v1;
        tb_last = w;
        wop     = w ? op1 : op0;
        wa      = w ? a1 : a0;
        wb      = w ? b1 : b0;
        e.id    = w;
        e.data  = alu_f(wop, wa, wb);
        sb.push_back(e);

        @(negedge clk);
        chk("idle_req0_ready", 64'(bus.req0_ready), 64'(!w));
        chk("idle_req1_ready", 64'(bus.req1_ready), 64'(w));
        chk("idle_alu_en", 64'(bus.alu_en), 64'd0);
        chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("idle_rsp_data_held", 64'(bus.rsp_data), 64'(last_data));
        @(posedge clk); #1;

        @(negedge clk);
        chk("exec_alu_en", 64'(bus.alu_en), 64'd1);
        chk("exec_alu_opcode", 64'(bus.alu_opcode), 64'(wop));
        chk("exec_alu_a", 64'(bus.alu_a), 64'(wa));
        chk("exec_alu_b", 64'(bus.alu_b), 64'(wb));
        chk("exec_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        chk("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
            chk("hold_rsp_data", 64'(bus.rsp_data), 64'(sb[0].data));
            chk("hold_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
            chk("hold_alu_en", 64'(bus.alu_en), 64'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;

        @(negedge clk);
        e = sb.pop_front();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
        chk("rsp_ready_blocked", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        chk("rsp_alu_en", 64'(bus.alu_en), 64'd0);
        last_data = e.data;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n     = 1'b1;
        tb_last   = 1'b1;
        last_data = '0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.req0_valid  = 1'b0;
        bus.req0_opcode = '0;
        bus.req0_a      = '0;
        bus.req0_b      = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_opcode = '0;
        bus.req1_a      = '0;
        bus.req1_b      = '0;
        bus.rsp_ready   = 1'b0;
        tb_last         = 1'b1;
        last_data       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // ADD with carry out into bit 32
        txn(1, 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 32'd0, 0);

        // Both valid from reset: alternating grants starting with req0
        pulse_reset();
        for (int i = 0; i < 8; i++)
            txn(1, 1, 3'd1, 32'd5, 32'd3, 3'd2, 32'hF0, 32'h3C, 0);

        // Response stalled for 5 cycles with both requesters waiting
        txn(1, 1, 3'd4, 32'hA5A5_0000, 32'h0000_5A5A, 3'd3, 32'h1, 32'h2, 5);

        // Compare-equal opcode from req1
        txn(0, 1, 3'd0, 32'd0, 32'd0, 3'd7, 32'h1234, 32'h1234, 0);

        // Reset during EXEC: outputs clear at once, transaction discarded
        bus.req0_valid  = 1'b1;
        bus.req0_opcode = 3'd0;
        bus.req0_a      = 32'd7;
        bus.req0_b      = 32'd8;
        bus.req1_valid  = 1'b0;
        bus.rsp_ready   = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        rst_n          = 1'b1;
        bus.req0_valid = 1'b0;
        tb_last        = 1'b1;
        last_data      = '0;
        @(negedge clk);
        chk("postreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("postreset_alu_en", 64'(bus.alu_en), 64'd0);
        @(posedge clk); #1;
        txn(0, 1, 3'd0, 32'd0, 32'd0, 3'd0, 32'd10, 32'd20, 0);

        // req1 continuously valid: one grant every 3 cycles
        for (int i = 0; i < 4; i++)
            txn(0, 1, 3'd0, 32'd0, 32'd0, 3'd5, 32'd0, 32'hDEAD, 0);

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
